// File: rtl/program_mem_arbiter_pkg.sv
// program_mem_arbiter_pkg: mode encoding and default widths shared by the arbiter and the program memory.
package program_mem_arbiter_pkg;
    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } mode_e;
    localparam int IA_W_DEF = 16;
    localparam int ID_W_DEF = 24;
endpackage

// File: rtl/program_mem_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; the pointer moves past the winner after every grant.
module rr_arbiter #(
    parameter int NCORE = 2
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [NCORE-1:0] REQ,
    output logic [NCORE-1:0] GNT
);
    localparam int PW = NCORE > 1 ? $clog2(NCORE) : 1;
    logic [PW-1:0] ptr_q, ptr_d, win;
    logic          found;
    always_comb begin
        GNT   = '0;
        win   = ptr_q;
        found = 1'b0;
        for (int k = 0; k < NCORE; k++) begin
            if (!found && REQ[(int'(ptr_q) + k) % NCORE]) begin
                found = 1'b1;
                win   = PW'((int'(ptr_q) + k) % NCORE);
            end
        end
        if (found) GNT[win] = 1'b1;
        ptr_d = !found ? ptr_q : (int'(win) == NCORE - 1) ? '0 : win + 1'b1;
    end
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
endmodule

// File: rtl/program_mem_arbiter.sv
// program_mem_arbiter: shares one program memory between round-robin core fetches and an exclusive host loader.
module program_mem_arbiter
    import program_mem_arbiter_pkg::*;
#(
    parameter int IA_W  = IA_W_DEF,
    parameter int ID_W  = ID_W_DEF,
    parameter int NCORE = 2
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic [NCORE-1:0]      F_REQ,
    input  logic [NCORE*IA_W-1:0] F_A,
    output logic [NCORE-1:0]      F_GNT,
    output logic [NCORE-1:0]      F_VLD,
    output logic [ID_W-1:0]       F_DQ,
    input  logic                  LD_REQ,
    output logic                  LD_ACK,
    input  logic                  LD_WE,
    input  logic [IA_W-1:0]       LD_A,
    input  logic [ID_W-1:0]       LD_DI,
    output logic [IA_W-1:0]       LD_CNT,
    output logic [IA_W-1:0]       MEM_A,
    output logic                  MEM_WE,
    output logic [ID_W-1:0]       MEM_DI,
    input  logic [ID_W-1:0]       MEM_DQ
);
    mode_e            state_q, state_d;
    logic [NCORE-1:0] req_m, f_vld_q;
    logic [ID_W-1:0]  f_dq_q, f_dq_d;
    logic [IA_W-1:0]  ld_cnt_q, ld_cnt_d, fetch_a;
    // A pending load request blocks fetch arbitration in the same cycle it appears.
    assign req_m = (state_q == RUN && !LD_REQ) ? F_REQ : '0;
    rr_arbiter #(.NCORE(NCORE)) u_arb (
        .CLK (CLK),
        .RSTn(RSTn),
        .REQ (req_m),
        .GNT (F_GNT)
    );
    always_comb begin
        fetch_a = '0;
        for (int i = 0; i < NCORE; i++) begin
            if (F_GNT[i]) fetch_a = F_A[i*IA_W +: IA_W];
        end
    end
    always_comb begin
        state_d  = LD_REQ ? LOAD : RUN;
        LD_ACK   = state_q == LOAD;
        MEM_WE   = state_q == LOAD && LD_REQ && LD_WE;
        MEM_A    = state_q == LOAD ? LD_A : fetch_a;
        MEM_DI   = LD_DI;
        f_dq_d   = |F_GNT ? MEM_DQ : f_dq_q;
        ld_cnt_d = (state_q == RUN && LD_REQ) ? '0 :
                   (MEM_WE && ld_cnt_q != '1) ? ld_cnt_q + 1'b1 : ld_cnt_q;
    end
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= RUN;
            f_vld_q  <= '0;
            f_dq_q   <= '0;
            ld_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            f_vld_q  <= F_GNT;
            f_dq_q   <= f_dq_d;
            ld_cnt_q <= ld_cnt_d;
        end
    end
    assign F_VLD  = f_vld_q;
    assign F_DQ   = f_dq_q;
    assign LD_CNT = ld_cnt_q;
endmodule
